// File: rtl/ahb_inte.sv
// AHB bridge to a RAM (data) slave and a ROM (instruction) slave: strobes, RMW sub-word stores, sign/zero-extended loads.
// Optional macro AHB_INTE_ALIGN_CHECK_EN turns misaligned halfword/word accesses into two-cycle error responses.
module ahb_inte (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] haddr_i,
  input  logic [31:0] hwdata_i,
  input  logic [3:0]  hprot_i,
  input  logic        hwrite_i,
  input  logic [2:0]  hsize_i,
  input  logic        is_signed_i,
  input  logic [31:0] ramdata_i,
  output logic        wr_en_ram_o,
  output logic        rd_en_ram_o,
  output logic        rd_en_rom_o,
  output logic [31:0] address_ram_o,
  output logic [31:0] address_rom_o,
  output logic [31:0] wr_data_ram_o,
  output logic        hready_1_o,
  output logic        hresp_1_o,
  output logic        hready_2_o,
  output logic        hresp_2_o,
  output logic [31:0] store_data_o,
  output logic [31:0] load_out_o,
  output logic [31:0] read_data_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RMW  = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        errSecond_q, errSecond_d;
  logic        errRam_q, errRam_d;
  logic        wrEnRam_q, wrEnRam_d;
  logic        rdEnRam_q, rdEnRam_d;
  logic        rdEnRom_q, rdEnRom_d;
  logic [31:0] addrRam_q, addrRam_d;
  logic [31:0] addrRom_q, addrRom_d;
  logic [31:0] wrData_q, wrData_d;
  logic [31:0] readData_q, readData_d;
  logic [1:0]  size_q, size_d;
  logic [1:0]  offset_q, offset_d;
  logic        signed_q, signed_d;
  logic        loadPend_q, loadPend_d;
  logic [31:0] storeData_q, storeData_d;

  logic        isData;
  logic        misaligned;
  logic        accErr;
  logic [31:0] wordAddr;
  logic [31:0] storeData;
  logic [31:0] laneMask;
  logic [31:0] mergedWord;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadOut;
  logic        unusedProt;

  assign unusedProt = ^hprot_i[3:1];
  assign isData     = hprot_i[0];
  assign wordAddr   = {haddr_i[31:2], 2'b00};

`ifdef AHB_INTE_ALIGN_CHECK_EN
  assign misaligned = ((hsize_i == 3'b001) && haddr_i[0]) ||
                      ((hsize_i == 3'b010) && (haddr_i[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign accErr = (hsize_i > 3'b010) || (!isData && hwrite_i) || misaligned;

  always_comb begin
    case (hsize_i)
      3'b000:  storeData = {4{hwdata_i[7:0]}};
      3'b001:  storeData = {2{hwdata_i[15:0]}};
      default: storeData = hwdata_i;
    endcase
  end

  // Lane selection ignores offset bits below the access size, so unchecked misaligned accesses snap down.
  always_comb begin
    case (size_q)
      2'b00:   laneMask = 32'h0000_00FF << {offset_q, 3'b000};
      2'b01:   laneMask = offset_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      default: laneMask = 32'hFFFF_FFFF;
    endcase
    mergedWord = (ramdata_i & ~laneMask) | (storeData_q & laneMask);
  end

  always_comb begin
    case (offset_q)
      2'b00:   byteSel = ramdata_i[7:0];
      2'b01:   byteSel = ramdata_i[15:8];
      2'b10:   byteSel = ramdata_i[23:16];
      default: byteSel = ramdata_i[31:24];
    endcase
    halfSel = offset_q[1] ? ramdata_i[31:16] : ramdata_i[15:0];
    case (size_q)
      2'b00:   loadOut = {{24{signed_q & byteSel[7]}}, byteSel};
      2'b01:   loadOut = {{16{signed_q & halfSel[15]}}, halfSel};
      default: loadOut = ramdata_i;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    errSecond_d = 1'b0;
    errRam_d    = errRam_q;
    wrEnRam_d   = 1'b0;
    rdEnRam_d   = 1'b0;
    rdEnRom_d   = 1'b0;
    addrRam_d   = addrRam_q;
    addrRom_d   = addrRom_q;
    wrData_d    = wrData_q;
    readData_d  = loadPend_q ? loadOut : readData_q;
    size_d      = size_q;
    offset_d    = offset_q;
    signed_d    = signed_q;
    loadPend_d  = 1'b0;
    storeData_d = storeData_q;
    case (state_q)
      IDLE: begin
        if (accErr) begin
          state_d  = ERR;
          errRam_d = isData;
        end else if (isData) begin
          addrRam_d = wordAddr;
          size_d    = hsize_i[1:0];
          offset_d  = haddr_i[1:0];
          if (!hwrite_i) begin
            rdEnRam_d  = 1'b1;
            signed_d   = is_signed_i;
            loadPend_d = 1'b1;
          end else if (hsize_i == 3'b010) begin
            wrEnRam_d = 1'b1;
            wrData_d  = hwdata_i;
          end else begin
            // Sub-word store: fetch the old word now, merge the new lanes next cycle.
            rdEnRam_d   = 1'b1;
            storeData_d = storeData;
            state_d     = RMW;
          end
        end else begin
          rdEnRom_d = 1'b1;
          addrRom_d = wordAddr;
        end
      end
      RMW: begin
        wrEnRam_d = 1'b1;
        wrData_d  = mergedWord;
        state_d   = IDLE;
      end
      ERR: begin
        if (!errSecond_q) errSecond_d = 1'b1;
        else              state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      errSecond_q <= 1'b0;
      errRam_q    <= 1'b0;
      wrEnRam_q   <= 1'b0;
      rdEnRam_q   <= 1'b0;
      rdEnRom_q   <= 1'b0;
      addrRam_q   <= '0;
      addrRom_q   <= '0;
      wrData_q    <= '0;
      readData_q  <= '0;
      size_q      <= 2'b10;
      offset_q    <= 2'b00;
      signed_q    <= 1'b0;
      loadPend_q  <= 1'b0;
      storeData_q <= '0;
    end else begin
      state_q     <= state_d;
      errSecond_q <= errSecond_d;
      errRam_q    <= errRam_d;
      wrEnRam_q   <= wrEnRam_d;
      rdEnRam_q   <= rdEnRam_d;
      rdEnRom_q   <= rdEnRom_d;
      addrRam_q   <= addrRam_d;
      addrRom_q   <= addrRom_d;
      wrData_q    <= wrData_d;
      readData_q  <= readData_d;
      size_q      <= size_d;
      offset_q    <= offset_d;
      signed_q    <= signed_d;
      loadPend_q  <= loadPend_d;
      storeData_q <= storeData_d;
    end
  end

  assign wr_en_ram_o   = wrEnRam_q;
  assign rd_en_ram_o   = rdEnRam_q;
  assign rd_en_rom_o   = rdEnRom_q;
  assign address_ram_o = addrRam_q;
  assign address_rom_o = addrRom_q;
  assign wr_data_ram_o = wrData_q;
  assign read_data_o   = readData_q;
  assign store_data_o  = storeData;
  assign load_out_o    = loadOut;

  assign hready_1_o = !((state_q == RMW) || ((state_q == ERR) && errRam_q && !errSecond_q));
  assign hresp_1_o  = (state_q == ERR) && errRam_q;
  assign hready_2_o = !((state_q == ERR) && !errRam_q && !errSecond_q);
  assign hresp_2_o  = (state_q == ERR) && !errRam_q;

endmodule

// File: tb/tb_ahb_inte.sv
// Directed self-checking bench for ahb_inte; idle cycles are word ROM fetches from address 0.
// Covers the AHB_INTE_ALIGN_CHECK_EN build when that macro is defined.
module tb_ahb_inte;

  logic        clk;
  logic        rst_n;
  logic [31:0] haddr, hwdata, ramdata;
  logic [3:0]  hprot;
  logic        hwrite, isSigned;
  logic [2:0]  hsize;
  logic        wrEnRam, rdEnRam, rdEnRom;
  logic [31:0] addressRam, addressRom, wrDataRam, storeData, loadOut, readData;
  logic        hready1, hresp1, hready2, hresp2;

  int totalChecks = 0;
  int badChecks   = 0;

  ahb_inte dut (
    .clk(clk), .rst_n(rst_n),
    .haddr_i(haddr), .hwdata_i(hwdata), .hprot_i(hprot), .hwrite_i(hwrite),
    .hsize_i(hsize), .is_signed_i(isSigned), .ramdata_i(ramdata),
    .wr_en_ram_o(wrEnRam), .rd_en_ram_o(rdEnRam), .rd_en_rom_o(rdEnRom),
    .address_ram_o(addressRam), .address_rom_o(addressRom), .wr_data_ram_o(wrDataRam),
    .hready_1_o(hready1), .hresp_1_o(hresp1), .hready_2_o(hready2), .hresp_2_o(hresp2),
    .store_data_o(storeData), .load_out_o(loadOut), .read_data_o(readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge so the DUT samples stable values.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] prot,
                               input logic write, input logic [2:0] size, input logic sgn);
    @(negedge clk);
    haddr    = addr;
    hwdata   = data;
    hprot    = prot;
    hwrite   = write;
    hsize    = size;
    isSigned = sgn;
  endtask

  task automatic applyIdle();
    applyStimulus(32'h0, 32'h0, 4'b0000, 1'b0, 3'b010, 1'b0);
  endtask

  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    haddr = '0; hwdata = '0; hprot = '0; hwrite = 1'b0; hsize = 3'b010; isSigned = 1'b0;
    ramdata = 32'hA5A5A5A5;
    #3;
    checkOutput("rst wr_en_ram", {31'b0, wrEnRam}, 32'd0);
    checkOutput("rst rd_en_ram", {31'b0, rdEnRam}, 32'd0);
    checkOutput("rst rd_en_rom", {31'b0, rdEnRom}, 32'd0);
    checkOutput("rst address_ram", addressRam, 32'h0);
    checkOutput("rst read_data", readData, 32'h0);
    checkOutput("rst hready_1", {31'b0, hready1}, 32'd1);
    checkOutput("rst hresp_2", {31'b0, hresp2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word write
    applyStimulus(32'h04, 32'hA5A5A5A5, 4'b0011, 1'b1, 3'b010, 1'b0);
    stepEdge();
    checkOutput("ww wr_en_ram", {31'b0, wrEnRam}, 32'd1);
    checkOutput("ww address_ram", addressRam, 32'h04);
    checkOutput("ww wr_data_ram", wrDataRam, 32'hA5A5A5A5);
    applyIdle();
    stepEdge();
    checkOutput("ww pulse end", {31'b0, wrEnRam}, 32'd0);
    checkOutput("ww data hold", wrDataRam, 32'hA5A5A5A5);

    // Word read
    applyStimulus(32'h04, 32'h0, 4'b0011, 1'b0, 3'b010, 1'b0);
    stepEdge();
    checkOutput("wr rd_en_ram", {31'b0, rdEnRam}, 32'd1);
    applyIdle();
    stepEdge();
    checkOutput("wr read_data", readData, 32'hA5A5A5A5);
    checkOutput("wr rd pulse end", {31'b0, rdEnRam}, 32'd0);

    // Byte reads signed / unsigned, halfword signed read
    ramdata = 32'h00008000;
    applyStimulus(32'h05, 32'h0, 4'b0011, 1'b0, 3'b000, 1'b1);
    stepEdge();
    applyIdle();
    stepEdge();
    checkOutput("sbyte read_data", readData, 32'hFFFFFF80);
    applyStimulus(32'h05, 32'h0, 4'b0011, 1'b0, 3'b000, 1'b0);
    stepEdge();
    applyIdle();
    stepEdge();
    checkOutput("ubyte read_data", readData, 32'h00000080);
    ramdata = 32'h80010000;
    applyStimulus(32'h06, 32'h0, 4'b0011, 1'b0, 3'b001, 1'b1);
    stepEdge();
    applyIdle();
    stepEdge();
    checkOutput("shalf read_data", readData, 32'hFFFF8001);

    // Halfword write (read-modify-write); inputs during RMW must be ignored
    ramdata = 32'hAABBCCDD;
    applyStimulus(32'h06, 32'h00001234, 4'b0011, 1'b1, 3'b001, 1'b0);
    #1;
    checkOutput("hw store_data", storeData, 32'h12341234);
    stepEdge();
    checkOutput("hw rmw rd_en_ram", {31'b0, rdEnRam}, 32'd1);
    checkOutput("hw rmw hready_1", {31'b0, hready1}, 32'd0);
    checkOutput("hw rmw no write", {31'b0, wrEnRam}, 32'd0);
    applyStimulus(32'h40, 32'hFFFFFFFF, 4'b0011, 1'b1, 3'b010, 1'b0);
    stepEdge();
    checkOutput("hw wr_en_ram", {31'b0, wrEnRam}, 32'd1);
    checkOutput("hw wr_data_ram", wrDataRam, 32'h1234CCDD);
    checkOutput("hw address_ram", addressRam, 32'h04);
    checkOutput("hw hready_1", {31'b0, hready1}, 32'd1);
    applyIdle();
    stepEdge();
    checkOutput("hw pulse end", {31'b0, wrEnRam}, 32'd0);

    // Byte write into lane 3
    applyStimulus(32'h03, 32'h000000EE, 4'b0011, 1'b1, 3'b000, 1'b0);
    stepEdge();
    applyIdle();
    stepEdge();
    checkOutput("bw wr_data_ram", wrDataRam, 32'hEEBBCCDD);
    checkOutput("bw address_ram", addressRam, 32'h00);

    // Instruction fetch; read_data must keep the last load result
    applyStimulus(32'h100, 32'h0, 4'b0010, 1'b0, 3'b010, 1'b0);
    stepEdge();
    checkOutput("fetch rd_en_rom", {31'b0, rdEnRom}, 32'd1);
    checkOutput("fetch address_rom", addressRom, 32'h100);
    checkOutput("fetch read_data", readData, 32'hFFFF8001);

    // ROM write -> ROM slave error
    applyStimulus(32'h100, 32'h0, 4'b0010, 1'b1, 3'b010, 1'b0);
    stepEdge();
    checkOutput("romw rd_en_rom", {31'b0, rdEnRom}, 32'd0);
    checkOutput("romw c1 hready_2", {31'b0, hready2}, 32'd0);
    checkOutput("romw c1 hresp_2", {31'b0, hresp2}, 32'd1);
    checkOutput("romw hresp_1", {31'b0, hresp1}, 32'd0);
    stepEdge();
    checkOutput("romw c2 hready_2", {31'b0, hready2}, 32'd1);
    checkOutput("romw c2 hresp_2", {31'b0, hresp2}, 32'd1);
    applyIdle();
    stepEdge();
    checkOutput("romw end hresp_2", {31'b0, hresp2}, 32'd0);

    // Unsupported size on a data read -> RAM slave error
    applyStimulus(32'h08, 32'h0, 4'b0011, 1'b0, 3'b011, 1'b0);
    stepEdge();
    checkOutput("usz rd_en_ram", {31'b0, rdEnRam}, 32'd0);
    checkOutput("usz hready_1", {31'b0, hready1}, 32'd0);
    checkOutput("usz hresp_1", {31'b0, hresp1}, 32'd1);
    applyIdle();
    stepEdge();
    stepEdge();
    checkOutput("usz end hresp_1", {31'b0, hresp1}, 32'd0);

    // Misaligned word write
    applyStimulus(32'h02, 32'h5A5A5A5A, 4'b0011, 1'b1, 3'b010, 1'b0);
    stepEdge();
`ifdef AHB_INTE_ALIGN_CHECK_EN
    checkOutput("mis wr_en_ram", {31'b0, wrEnRam}, 32'd0);
    checkOutput("mis c1 hready_1", {31'b0, hready1}, 32'd0);
    checkOutput("mis c1 hresp_1", {31'b0, hresp1}, 32'd1);
    applyIdle();
    stepEdge();
    checkOutput("mis c2 hready_1", {31'b0, hready1}, 32'd1);
    checkOutput("mis c2 hresp_1", {31'b0, hresp1}, 32'd1);
    stepEdge();
    checkOutput("mis end hresp_1", {31'b0, hresp1}, 32'd0);
`else
    checkOutput("mis wr_en_ram", {31'b0, wrEnRam}, 32'd1);
    checkOutput("mis address_ram", addressRam, 32'h00);
    checkOutput("mis hresp_1", {31'b0, hresp1}, 32'd0);
    applyIdle();
    stepEdge();
`endif

    // Reset in the middle of an RMW abandons the write
    applyStimulus(32'h06, 32'h00001234, 4'b0011, 1'b1, 3'b001, 1'b0);
    stepEdge();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstrmw hready_1", {31'b0, hready1}, 32'd1);
    checkOutput("rstrmw rd_en_ram", {31'b0, rdEnRam}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    haddr = '0; hwdata = '0; hprot = '0; hwrite = 1'b0; hsize = 3'b010; isSigned = 1'b0;
    stepEdge();
    checkOutput("rstrmw no write", {31'b0, wrEnRam}, 32'd0);
    checkOutput("rstrmw wr_data", wrDataRam, 32'h0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/ahb_inte.md
AHB_INTE -- requirements
Module: ahb_inte

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset; asynchronous, active-low.
REQ-003 haddr  input  32  byte address, sampled on each rising edge.
REQ-004 hwdata  input  32  write data, sampled with haddr.
REQ-005 hprot  input  4  protection; bit0=0 instruction fetch (ROM), bit0=1 data access (RAM); bits[3:1] ignored.
REQ-006 hwrite  input  1  1=write, 0=read.
REQ-007 hsize  input  3  000 byte, 001 halfword, 010 word; 011..111 unsupported.
REQ-008 is_signed  input  1  1=sign-extend byte/halfword loads, 0=zero-extend.
REQ-009 ramdata  input  32  asynchronous read data from RAM at address_ram.
REQ-010 wr_en_ram, rd_en_ram, rd_en_rom  output  1 each  registered RAM write, RAM read, ROM read strobes.
REQ-011 address_ram, address_rom  output  32 each  registered word-aligned addresses (haddr with bits[1:0] cleared).
REQ-012 wr_data_ram  output  32  registered RAM write word.
REQ-013 hready_1/hresp_1 (RAM slave), hready_2/hresp_2 (ROM slave)  output  1 each  AHB ready/error response.
REQ-014 store_data  output  32  combinational lane-replicated hwdata: byte→{4{hwdata[7:0]}}, half→{2{hwdata[15:0]}}, word→hwdata.
REQ-015 load_out  output  32  combinational extract/extend of ramdata using registered size, offset and is_signed.
REQ-016 read_data  output  32  registered load result.

Function
REQ-017 States IDLE, RMW, ERR; IDLE→RMW on byte/halfword RAM write; RMW→IDLE after one cycle; IDLE→ERR on error; ERR→IDLE after two cycles.
REQ-018 Strobes are single-cycle pulses, deasserted in any cycle without a new access.
REQ-019 Word RAM write (hprot[0]=1, hwrite=1, hsize=010): next edge wr_en_ram=1, address_ram set, wr_data_ram=hwdata.
REQ-020 Byte/halfword RAM write: edge 1 rd_en_ram=1, hready_1=0, state RMW; edge 2 wr_en_ram=1, wr_data_ram=ramdata with addressed lane(s) replaced by store_data lanes, hready_1=1; inputs ignored during RMW.
REQ-021 RAM read: edge 1 rd_en_ram=1 and offset/size/sign registered; edge 2 read_data<=load_out.
REQ-022 Load extraction: byte lane=offset[1:0]; halfword lane=offset[1]; word=ramdata unchanged.
REQ-023 Fetch (hprot[0]=0, hwrite=0): next edge rd_en_rom=1, address_rom set; read_data unaffected.
REQ-024 Errors: unsupported hsize, ROM write, or misaligned access (REQ-031); no strobe asserted; the addressed slave drives cycle 1 hready=0/hresp=1, cycle 2 hready=1/hresp=1.
REQ-025 Outside RMW/ERR, hready_1=hready_2=1 and hresp_1=hresp_2=0.
REQ-026 read_data, address_ram, address_rom, wr_data_ram hold their value until next update.

Reset
REQ-027 rst_n low immediately forces state IDLE, all strobes 0, addresses 0, wr_data_ram 0, read_data 0, hresp_* 0, hready_* 1.
REQ-028 Reset during RMW or ERR abandons the access; no write issued.
REQ-029 First access accepted on first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro AHB_INTE_ALIGN_CHECK_EN selects misalignment checking.
REQ-031 Defined: halfword with haddr[0]=1 or word with haddr[1:0]!=0 raises error per REQ-024.
REQ-032 Undefined: no misalignment error; offending low address bits treated as 0 for lane selection.

Verification
REQ-033 Word write haddr=0x04, hwdata=0xA5A5A5A5, hprot=0011 -> wr_en_ram=1, address_ram=0x04, wr_data_ram=0xA5A5A5A5 for one cycle.
REQ-034 Word read 0x04, ramdata=0xA5A5A5A5 -> rd_en_ram=1, then read_data=0xA5A5A5A5.
REQ-035 Signed byte read 0x05, ramdata=0x00008000 -> read_data=0xFFFFFF80; unsigned -> 0x00000080.
REQ-036 Halfword write 0x06 hwdata=0x1234, ramdata=0xAABBCCDD -> hready_1 low one cycle, then wr_en_ram=1, wr_data_ram=0x1234CCDD.
REQ-037 Macro defined, word write 0x02 -> no wr_en_ram; hready_1=0/hresp_1=1 then hready_1=1/hresp_1=1, then idle.
REQ-038 Fetch hprot=0010, haddr=0x100 -> rd_en_rom=1, address_rom=0x100; same with hwrite=1 -> hresp_2 two-cycle error.
